// File: rtl/minhash_sketch.sv
// MinHash sketcher: validates one-hot k-mer fragments, hashes each into NUM_HASH
//   16-bit lanes (one lane per cycle) and tracks the running minimum per lane.
// Latency: lane i updated NUM_HASH edge T+1+i after acceptance edge T; signature valid
//   NUM_HASH+1 cycles after the last fragment of a sketch is accepted.
// Backpressure: in_ready drops while hashing or while a signature waits for sig_ready;
//   the signature is held stable until the sink takes it.
//
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid/in_ready          - fragment handshake, in_fragment nibble 0 = bits [3:0]
//   sig_valid/sig_ready        - signature handshake, lane i = sig_data[16i+15:16i]
//   bad_frag                   - one-cycle pulse after a malformed fragment is dropped

package proj_pkg;
    localparam int EXTENDER_OUT_PART_LEN_ONE_HOT = 32;
endpackage

module minhash_sketch #(
    parameter int FRAG_W           = proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT,
    parameter int NUM_HASH         = 4,
    parameter int FRAGS_PER_SKETCH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [FRAG_W-1:0]      in_fragment,
    output logic                   in_ready,
    output logic                   sig_valid,
    output logic [NUM_HASH*16-1:0] sig_data,
    input  logic                   sig_ready,
    output logic                   bad_frag
);
    localparam int HASH_W = 16;
    localparam int NIB    = FRAG_W / 4;
    localparam int NCHUNK = (FRAG_W + HASH_W - 1) / HASH_W;
    localparam int PAD_W  = NCHUNK * HASH_W;
    localparam int LANE_W = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
    localparam int CNT_W  = $clog2(FRAGS_PER_SKETCH + 1);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_HASH - 1);
    localparam logic [CNT_W-1:0]  LAST_FRAG = CNT_W'(FRAGS_PER_SKETCH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t            state;
    logic [LANE_W-1:0] lane;
    logic [CNT_W-1:0]  frag_cnt;
    logic [HASH_W-1:0] fold_q;
    logic [HASH_W-1:0] min_q [NUM_HASH];

    // Fragment validation and fold (XOR of zero-padded 16-bit chunks).
    logic              frag_ok;
    logic [PAD_W-1:0]  frag_pad;
    logic [HASH_W-1:0] fold;

    always_comb begin
        frag_ok = 1'b1;
        for (int n = 0; n < NIB; n++) begin
            case (in_fragment[4*n +: 4])
                4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
                default: frag_ok = 1'b0;
            endcase
        end
        frag_pad = '0;
        frag_pad[FRAG_W-1:0] = in_fragment;
        fold = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            fold = fold ^ frag_pad[HASH_W*c +: HASH_W];
        end
    end

    // Per-lane hash of the latched fold. All arithmetic is 16 bits wide, so the
    // multiply keeps only the low half of the product by construction.
    logic [HASH_W-1:0] lane_idx;
    logic [HASH_W-1:0] seed;
    logic [HASH_W-1:0] mult;
    logic [HASH_W-1:0] hash_val;

    always_comb begin
        lane_idx = HASH_W'(lane);
        seed     = 16'h7F4A + lane_idx * 16'h9E37;
        mult     = 16'h6A09 + (lane_idx << 1);
        hash_val = (fold_q ^ seed) * mult;
    end

    // The signature is the minima registers themselves; they only change in HASH
    // or on the signature handshake, so they are stable while sig_valid waits.
    always_comb begin
        sig_data = '0;
        for (int i = 0; i < NUM_HASH; i++) begin
            sig_data[HASH_W*i +: HASH_W] = min_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            sig_valid <= 1'b0;
            bad_frag  <= 1'b0;
            lane      <= '0;
            frag_cnt  <= '0;
            fold_q    <= '0;
            for (int i = 0; i < NUM_HASH; i++) begin
                min_q[i] <= 16'hFFFF;
            end
        end else begin
            bad_frag <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (frag_ok) begin
                            fold_q   <= fold;
                            lane     <= '0;
                            in_ready <= 1'b0;
                            state    <= HASH;
                        end else begin
                            bad_frag <= 1'b1;
                        end
                    end
                end
                HASH: begin
                    // Ties keep the old minimum.
                    if (hash_val < min_q[lane]) begin
                        min_q[lane] <= hash_val;
                    end
                    if (lane == LAST_LANE) begin
                        lane     <= '0;
                        frag_cnt <= frag_cnt + 1'b1;
                        if (frag_cnt == LAST_FRAG) begin
                            sig_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                EMIT: begin
                    if (sig_ready) begin
                        for (int i = 0; i < NUM_HASH; i++) begin
                            min_q[i] <= 16'hFFFF;
                        end
                        frag_cnt  <= '0;
                        sig_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    sig_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_minhash_sketch.sv
// Directed bench for minhash_sketch: three instances (8, 1 and 2 fragments per sketch)
// Latency: n/a (testbench)
// Backpressure: bench drives sig_ready directly per test step
module tb_minhash_sketch;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       in_valid  = '0;
    logic [2:0]       sig_ready = '0;
    logic [2:0]       in_ready;
    logic [2:0]       sig_valid;
    logic [2:0]       bad_frag;
    logic [2:0][31:0] frag      = '0;
    logic [2:0][63:0] sig_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] sigq [$];
    logic [15:0] mdl [4];

    // Signatures taken by the sink of the 8-fragment instance.
    always @(negedge clk) begin
        if (sig_valid[0] && sig_ready[0]) sigq.push_back(sig_data[0]);
    end

    minhash_sketch #(.FRAG_W(32), .NUM_HASH(4), .FRAGS_PER_SKETCH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_fragment(frag[0]),
        .in_ready(in_ready[0]), .sig_valid(sig_valid[0]), .sig_data(sig_data[0]),
        .sig_ready(sig_ready[0]), .bad_frag(bad_frag[0]));

    minhash_sketch #(.FRAG_W(32), .NUM_HASH(4), .FRAGS_PER_SKETCH(1)) u_one (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_fragment(frag[1]),
        .in_ready(in_ready[1]), .sig_valid(sig_valid[1]), .sig_data(sig_data[1]),
        .sig_ready(sig_ready[1]), .bad_frag(bad_frag[1]));

    minhash_sketch #(.FRAG_W(32), .NUM_HASH(4), .FRAGS_PER_SKETCH(2)) u_two (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_fragment(frag[2]),
        .in_ready(in_ready[2]), .sig_valid(sig_valid[2]), .sig_data(sig_data[2]),
        .sig_ready(sig_ready[2]), .bad_frag(bad_frag[2]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden hash: fold of a 32-bit fragment, seed/multiplier from the lane index.
    function automatic logic [15:0] hfn(input logic [31:0] f, input int i);
        logic [15:0] fold, s, m;
        logic [31:0] p;
        fold = f[15:0] ^ f[31:16];
        s    = 16'(32'h7F4A + i * 32'h9E37);
        m    = 16'(32'h6A09 + 2 * i);
        p    = {16'h0, fold ^ s} * {16'h0, m};
        return p[15:0];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 4; i++) mdl[i] = 16'hFFFF;
    endtask

    task automatic mdl_add(input logic [31:0] f);
        logic [15:0] h;
        for (int i = 0; i < 4; i++) begin
            h = hfn(f, i);
            if (h < mdl[i]) mdl[i] = h;
        end
    endtask

    function automatic logic [63:0] mdl_sig();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic logic [31:0] rand_frag();
        logic [31:0] f;
        for (int k = 0; k < 8; k++) f[4*k +: 4] = 4'(1 << $urandom_range(3, 0));
        return f;
    endfunction

    // Offer a fragment and return the cycle number of its acceptance edge.
    task automatic send(input int d, input logic [31:0] f, output int t_acc);
        in_valid[d] = 1'b1;
        frag[d]     = f;
        for (int n = 0; n < 200 && !in_ready[d]; n++) tick();
        check("accept_wait", {63'd0, in_ready[d]}, 64'd1);
        tick();
        t_acc       = cyc;
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_sig(input int d);
        for (int n = 0; n < 200 && !sig_valid[d]; n++) tick();
        check("sig_wait", {63'd0, sig_valid[d]}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc [24];
        logic [31:0] ff;
        logic [63:0] exp_sig [3];

        // Reset values
        #12;
        check("rst_in_ready",  {63'd0, in_ready[0]},  64'd1);
        check("rst_sig_valid", {63'd0, sig_valid[0]}, 64'd0);
        check("rst_bad_frag",  {63'd0, bad_frag[0]},  64'd0);
        check("rst_sig_data",  sig_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        #1 rst_n = 1'b1;
        tick();

        // Known hash: all-A fragment folds to zero
        send(1, 32'h1111_1111, t);
        tick(); tick(); tick();
        check("known_valid_early", {63'd0, sig_valid[1]}, 64'd0);
        check("known_ready_low",   {63'd0, in_ready[1]},  64'd0);
        tick();
        check("known_valid_rise",  {63'd0, sig_valid[1]}, 64'd1);
        check("known_lane0",       {48'd0, sig_data[1][15:0]}, 64'h1D9A);
        mdl_reset();
        mdl_add(32'h1111_1111);
        check("known_all_lanes",   sig_data[1], mdl_sig());
        sig_ready[1] = 1'b1;
        tick();
        sig_ready[1] = 1'b0;
        check("known_valid_drop",  {63'd0, sig_valid[1]}, 64'd0);
        check("known_ready_back",  {63'd0, in_ready[1]},  64'd1);

        // Malformed fragments: two-hot nibble, then an empty nibble
        send(0, 32'h1111_1113, t);
        check("bad1_pulse", {63'd0, bad_frag[0]}, 64'd1);
        check("bad1_ready", {63'd0, in_ready[0]}, 64'd1);
        tick();
        check("bad1_end",   {63'd0, bad_frag[0]}, 64'd0);
        send(0, 32'h1111_0111, t);
        check("bad2_pulse", {63'd0, bad_frag[0]}, 64'd1);
        check("bad2_ready", {63'd0, in_ready[0]}, 64'd1);
        tick();
        check("bad2_end",   {63'd0, bad_frag[0]}, 64'd0);

        // Minimum tracking with idle gaps and a stalled sink
        sigq.delete();
        mdl_reset();
        for (int k = 0; k < 8; k++) begin
            ff = rand_frag();
            mdl_add(ff);
            send(0, ff, t);
            if (k != 7) repeat ($urandom_range(7, 4)) tick();
        end
        tick(); tick(); tick();
        check("min_valid_early", {63'd0, sig_valid[0]}, 64'd0);
        tick();
        check("min_valid_rise",  {63'd0, sig_valid[0]}, 64'd1);
        for (int k = 0; k < 10; k++) begin
            check("min_hold_data", sig_data[0], mdl_sig());
            tick();
        end
        check("min_hold_valid", {63'd0, sig_valid[0]}, 64'd1);
        sig_ready[0] = 1'b1;
        tick();
        sig_ready[0] = 1'b0;
        check("min_valid_drop", {63'd0, sig_valid[0]}, 64'd0);
        check("min_ready_back", {63'd0, in_ready[0]},  64'd1);
        repeat (20) tick();
        check("min_sig_count", 64'(sigq.size()), 64'd1);
        if (sigq.size() > 0) check("min_sig_data", sigq[0], mdl_sig());

        // Back-to-back sketches with sink always ready
        sigq.delete();
        sig_ready[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k % 8 == 0) mdl_reset();
            ff = rand_frag();
            mdl_add(ff);
            send(0, ff, acc[k]);
            if (k % 8 == 7) exp_sig[k / 8] = mdl_sig();
            if (k % 8 != 0) check("b2b_spacing", 64'(acc[k] - acc[k-1]), 64'd5);
        end
        repeat (10) tick();
        check("b2b_sig_count", 64'(sigq.size()), 64'd3);
        for (int s = 0; s < 3 && s < sigq.size(); s++) check("b2b_sig_data", sigq[s], exp_sig[s]);

        // Reset during lane 2 of the fifth fragment
        sigq.delete();
        for (int k = 0; k < 5; k++) send(0, rand_frag(), t);
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, sig_valid[0]}, 64'd0);
        check("mid_rst_ready", {63'd0, in_ready[0]},  64'd1);
        check("mid_rst_bad",   {63'd0, bad_frag[0]},  64'd0);
        check("mid_rst_data",  sig_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("mid_rst_hold",  sig_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
        rst_n = 1'b1;
        tick();
        mdl_reset();
        for (int k = 0; k < 8; k++) begin
            ff = rand_frag();
            mdl_add(ff);
            send(0, ff, t);
        end
        repeat (10) tick();
        check("post_rst_count", 64'(sigq.size()), 64'd1);
        if (sigq.size() > 0) check("post_rst_data", sigq[0], mdl_sig());
        sig_ready[0] = 1'b0;

        // Same fragment twice: equal hashes leave minima unchanged
        ff = 32'h4821_4812;
        mdl_reset();
        mdl_add(ff);
        send(2, ff, t);
        send(2, ff, t);
        wait_sig(2);
        check("twice_sig", sig_data[2], mdl_sig());
        sig_ready[2] = 1'b1;
        tick();
        sig_ready[2] = 1'b0;
        check("twice_valid_drop", {63'd0, sig_valid[2]}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/minhash_sketch.md
# minhash_sketch

Downstream consumer of `proj_top`. Accepts one-hot encoded k-mer fragments on a valid/ready handshake and rejects any fragment with a malformed base. For each accepted fragment it computes `NUM_HASH` 16-bit hashes, one per cycle, and keeps the running minimum per hash lane. After `FRAGS_PER_SKETCH` accepted fragments it emits the MinHash signature and holds it until the sink takes it.

## Interface
- `FRAG_W`, default `proj_pkg::EXTENDER_OUT_PART_LEN_ONE_HOT`: fragment width in bits; must be a multiple of 4 (one 4-bit one-hot nibble per base).
- `NUM_HASH`, default 4: number of hash lanes, range 1..16.
- `FRAGS_PER_SKETCH`, default 8: accepted fragments per signature, at least 1.
- `HASH_W`, fixed at 16 (localparam): lane width.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: `in_fragment` is valid this cycle.
- `in_fragment`, in, `FRAG_W`: one-hot fragment. Nibble 0 is bits [3:0].
- `in_ready`, out, 1: block accepts a fragment this cycle.
- `sig_valid`, out, 1: signature available.
- `sig_data`, out, `NUM_HASH*16`: lane i occupies bits [16i+15:16i].
- `sig_ready`, in, 1: sink takes the signature.
- `bad_frag`, out, 1: one-cycle pulse when a malformed fragment is dropped.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - HASH: `in_ready`=0; lane index `h` runs 0..`NUM_HASH`-1.
  - EMIT: `sig_valid`=1, `in_ready`=0.
- IDLE:
  - Acceptance is `in_valid & in_ready` at a rising edge.
  - If every nibble has exactly one bit set, latch the fragment, compute `fold`, set `h`=0, go to HASH.
  - Otherwise drop the fragment: stay in IDLE, pulse `bad_frag` the next cycle, leave counters and minima unchanged.
- Fold:
  - Zero-pad the fragment on the MSB side to a multiple of 16 bits.
  - `fold` is the XOR of all 16-bit chunks.
- Hash for lane i:
  - `h_i = ((fold ^ SEED_i) * MULT_i) mod 2^16`.
  - `SEED_i = (16'h7F4A + i*16'h9E37) mod 2^16`.
  - `MULT_i = (16'h6A09 + 2i) mod 2^16`; always odd.
  - Only the low 16 bits of the product are kept.
- HASH, one lane per cycle:
  - `min_i <= (h_i < min_i) ? h_i : min_i`, unsigned compare; ties keep the old value.
  - On the last lane, increment `frag_cnt`.
  - If `frag_cnt` was `FRAGS_PER_SKETCH`-1, go to EMIT; otherwise go to IDLE.
- EMIT:
  - `sig_data` is the registered minima. It stays stable while `sig_valid`=1 and `sig_ready`=0.
  - On `sig_valid & sig_ready`: all minima become 16'hFFFF, `frag_cnt` becomes 0, go to IDLE.
- Reset value of every minimum is 16'hFFFF. It is restored after each emitted signature.

## Timing
- Reset, asynchronous:
  - State goes to IDLE; `frag_cnt`=0; `h`=0; minima=16'hFFFF.
  - `sig_valid`=0, `bad_frag`=0, `sig_data`=all ones.
  - `in_ready` reads 1 but nothing is accepted while `rst_n`=0.
  - Reset asserted mid-HASH or mid-EMIT discards the partial sketch or pending signature with no output.
- Per accepted fragment:
  - Acceptance edge T.
  - Lane i is updated at edge T+1+i.
  - `in_ready` is 0 from T+ through T+`NUM_HASH`, and returns to 1 after edge T+`NUM_HASH`.
  - Maximum throughput is one fragment per `NUM_HASH`+1 cycles.
- Signature:
  - `sig_valid` rises after edge T+`NUM_HASH` of the final fragment; signature latency is `NUM_HASH`+1 cycles from the last acceptance.
  - After the handshake edge, `sig_valid`=0 and `in_ready`=1 in the next cycle.
  - A fragment offered while `sig_valid`=1 is not accepted.
- Handshake rules:
  - The upstream must hold `in_valid` and `in_fragment` stable until accepted.
  - `in_ready` does not depend combinationally on `in_valid`.
  - `sig_ready` may be high before `sig_valid`.
- `bad_frag` is registered: high in the cycle after the dropped-fragment edge, for exactly one cycle.

## Test plan
- Known hash value:
  - Stimulus: `FRAG_W`=32, `FRAGS_PER_SKETCH`=1, `NUM_HASH`=4; offer `in_fragment`=32'h11111111, all A, so `fold`=0.
  - Required: `sig_valid` rises 5 cycles after acceptance, `sig_data`[15:0]=16'h1D9A, and lanes 1..3 match the golden model.
- Minimum tracking:
  - Stimulus: default parameters; 8 random valid fragments with idle gaps; sink holds `sig_ready` low for 10 cycles.
  - Required: every lane equals the golden-model minimum; `sig_data` is stable for all 10 cycles; exactly one signature is emitted.
- Malformed fragment:
  - Stimulus: one fragment containing nibble 4'b0011, followed by one containing 4'b0000.
  - Required: two `bad_frag` pulses; `frag_cnt` and minima unchanged; `in_ready` stays 1.
- Back-to-back sketches:
  - Stimulus: 24 fragments with `in_valid` held high and `sig_ready` tied 1.
  - Required: 3 signatures; each starts from minima 16'hFFFF with no carry-over; acceptance spacing is exactly 5 cycles within a sketch.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during HASH lane 2 of the 5th fragment, then release and run 8 new fragments.
  - Required: outputs take reset values immediately; the next signature reflects only the 8 new fragments.
- Unchanged minimum:
  - Stimulus: `FRAGS_PER_SKETCH`=2; the same fragment twice.
  - Required: the signature equals the single-fragment result; the equal compare leaves the minima unchanged.
